keccak_absorb_buffer: RTL and testbench

//  Input stage directly upstream of the Keccak permutation core.

---
 rtl/keccak_absorb_buffer_pkg.sv | 38 +++
 rtl/keccak_absorb_buffer.sv | 119 +++++++++++
 tb/tb_keccak_absorb_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keccak_absorb_buffer_pkg.sv
// Shared types, constants and the pad10*1 lane helper for the Keccak absorb stage.
package keccak_absorb_buffer_pkg;

  localparam int unsigned KEC_N     = 64;
  localparam int unsigned NUM_PLANE = 5;
  localparam int unsigned NUM_SHEET = 5;

  typedef logic [KEC_N-1:0] k_lane;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL
  } absorb_state_e;

  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] DS_SHAKE  = 8'h1F;
  localparam logic [7:0] DS_KECCAK = 8'h01;

  // Keeps bytes below nbytes, places ds at byte nbytes, zeroes the rest;
  // fin sets bit 63 (the closing 1 of pad10*1 when this is the last rate lane).
  function automatic k_lane pad_lane(k_lane d, logic [3:0] nbytes, logic [7:0] ds, logic fin);
    k_lane r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < {28'b0, nbytes})
        r[8*b +: 8] = d[8*b +: 8];
      else if (b == {28'b0, nbytes})
        r[8*b +: 8] = ds;
      else
        r[8*b +: 8] = 8'h00;
    end
    if (fin)
      r[KEC_N-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/keccak_absorb_buffer.sv
// Packs a 64-bit lane stream into rate blocks with inline pad10*1 and hands
// each block to the permutation core over a valid/ready handshake.
module keccak_absorb_buffer
  import keccak_absorb_buffer_pkg::*;
#(
  parameter int unsigned RATE_WORDS = 17,
  parameter logic [7:0]  DS_BYTE    = DS_SHA3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [KEC_N-1:0]            in_data,
  input  logic                        in_last,
  input  logic [3:0]                  in_bytes,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [RATE_WORDS*KEC_N-1:0] blk_data,
  output logic                        blk_last
);

  localparam int unsigned     CW       = $clog2(RATE_WORDS);
  localparam logic [CW-1:0]   LAST     = CW'(RATE_WORDS - 1);
  localparam k_lane           TOP_BIT  = {1'b1, {(KEC_N-1){1'b0}}};

  absorb_state_e   state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            pad_pend;
  k_lane           lanes [RATE_WORDS];

  logic            in_fire;
  logic            blk_fire;
  logic            short_last;
  logic            pad_now;
  logic            at_last;
  k_lane           pad_word;

  always_comb begin
    state_nxt  = state;
    in_ready   = (state == FILL);
    blk_valid  = (state == FULL);
    in_fire    = in_valid & in_ready;
    blk_fire   = blk_valid & blk_ready;
    short_last = in_last & (in_bytes < 4'd8);
    at_last    = (cnt == LAST);
    pad_now    = (state == PAD) | (in_fire & short_last);
    pad_word   = (state == PAD) ? pad_lane('0, 4'd0, DS_BYTE, at_last)
                                : pad_lane(in_data, in_bytes, DS_BYTE, at_last);
    case (state)
      FILL: begin
        if (in_fire) begin
          if (short_last)
            state_nxt = FULL;
          else if (at_last)
            state_nxt = FULL;
          else if (in_last)
            state_nxt = PAD;
        end
      end
      PAD:     state_nxt = FULL;
      FULL: begin
        if (blk_fire)
          state_nxt = pad_pend ? PAD : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= FILL;
    else
      state <= state_nxt;
  end

  // The padding path serves both an inline short last word and the PAD state:
  // the word at cnt is replaced, lanes above are cleared, the top bit is closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pad_pend <= 1'b0;
      blk_last <= 1'b0;
      for (int unsigned i = 0; i < RATE_WORDS; i++)
        lanes[i] <= '0;
    end else if (pad_now) begin
      lanes[cnt] <= pad_word;
      for (int unsigned i = 0; i < RATE_WORDS; i++)
        if (i > 32'(cnt))
          lanes[i] <= '0;
      if (!at_last)
        lanes[LAST] <= TOP_BIT;
      blk_last <= 1'b1;
      pad_pend <= 1'b0;
    end else if (in_fire) begin
      lanes[cnt] <= in_data;
      if (!at_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        blk_last <= 1'b0;
        pad_pend <= in_last;
      end
    end else if (blk_fire) begin
      cnt      <= '0;
      blk_last <= 1'b0;
      for (int unsigned i = 0; i < RATE_WORDS; i++)
        lanes[i] <= '0;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int unsigned i = 0; i < RATE_WORDS; i++)
      blk_data[KEC_N*i +: KEC_N] = lanes[i];
  end

  a_in_bytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_last) |-> (in_bytes <= 4'd8));

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Directed bench for keccak_absorb_buffer with SHA3-256 rate and DS byte.
module tb_keccak_absorb_buffer;

  localparam int unsigned RW = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              in_last;
  logic [3:0]        in_bytes;
  logic              blk_valid;
  logic              blk_ready;
  logic [RW*64-1:0]  blk_data;
  logic              blk_last;

  logic [63:0]       exp_l [RW];
  int                checks = 0;
  int                errors = 0;

  keccak_absorb_buffer #(.RATE_WORDS(RW), .DS_BYTE(8'h06)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < RW; i++)
      exp_l[i] = '0;
  endtask

  task automatic check_block(input string tag);
    for (int i = 0; i < RW; i++)
      check_eq($sformatf("%s_lane%0d", tag, i), blk_data[64*i +: 64], exp_l[i]);
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready)
      check_eq("send_timeout", 64'(in_ready), 64'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
  endtask

  task automatic handshake();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_bytes = 4'd0; blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check_eq("rst_blk_valid", 64'(blk_valid), 64'd0);
    check_eq("rst_blk_last", 64'(blk_last), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    clear_exp();
    check_block("rst");

    // 1: empty message, block valid the cycle after acceptance
    send(64'h0, 1'b1, 4'd0);
    check_eq("empty_valid", 64'(blk_valid), 64'd1);
    check_eq("empty_last", 64'(blk_last), 64'd1);
    clear_exp();
    exp_l[0]  = 64'h06;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_block("empty");
    handshake();
    check_eq("empty_done_valid", 64'(blk_valid), 64'd0);
    check_eq("empty_done_ready", 64'(in_ready), 64'd1);

    // 2: "abc"
    send(64'h636261, 1'b1, 4'd3);
    clear_exp();
    exp_l[0]  = 64'h0000_0000_0663_6261;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_eq("abc_last", 64'(blk_last), 64'd1);
    check_block("abc");
    handshake();

    // full 8-byte last word short of the rate: goes through PAD (N+2)
    send(64'h0123_4567_89AB_CDEF, 1'b1, 4'd8);
    check_eq("w8_pad_valid", 64'(blk_valid), 64'd0);
    check_eq("w8_pad_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("w8_valid", 64'(blk_valid), 64'd1);
    check_eq("w8_last", 64'(blk_last), 64'd1);
    clear_exp();
    exp_l[0]  = 64'h0123_4567_89AB_CDEF;
    exp_l[1]  = 64'h06;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_block("w8");
    handshake();

    // 3: 17 full words, last with 8 bytes -> data block then all-padding block
    clear_exp();
    for (int i = 0; i < RW; i++) begin
      exp_l[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      send(exp_l[i], (i == RW-1), 4'd8);
    end
    check_eq("full17_valid", 64'(blk_valid), 64'd1);
    check_eq("full17_last", 64'(blk_last), 64'd0);
    check_block("full17");
    handshake();
    check_eq("full17_pad_valid", 64'(blk_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("padblk_valid", 64'(blk_valid), 64'd1);
    check_eq("padblk_last", 64'(blk_last), 64'd1);
    clear_exp();
    exp_l[0]  = 64'h06;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_block("padblk");
    handshake();

    // 4: 16 words then 7-byte last word in the final lane
    clear_exp();
    for (int i = 0; i < RW-1; i++) begin
      exp_l[i] = 64'h1000 + 64'(i);
      send(exp_l[i], 1'b0, 4'd0);
    end
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd7);
    exp_l[16] = 64'h86FF_FFFF_FFFF_FFFF;
    check_eq("b7_valid", 64'(blk_valid), 64'd1);
    check_eq("b7_last", 64'(blk_last), 64'd1);
    check_block("b7");
    handshake();
    check_eq("b7_single", 64'(blk_valid), 64'd0);

    // 5: backpressure, a held input word must wait for the handshake
    send(64'hBEEF, 1'b1, 4'd2);
    in_valid = 1'b1; in_data = 64'h77; in_last = 1'b1; in_bytes = 4'd1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(blk_valid), 64'd1);
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      check_eq("hold_lane0", blk_data[63:0], 64'h06BEEF);
      check_eq("hold_lane16", blk_data[16*64 +: 64], 64'h8000_0000_0000_0000);
      check_eq("hold_last", 64'(blk_last), 64'd1);
    end
    handshake();
    check_eq("hold_rel_valid", 64'(blk_valid), 64'd0);
    check_eq("hold_rel_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0;
    clear_exp();
    exp_l[0]  = 64'h0677;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_eq("held_valid", 64'(blk_valid), 64'd1);
    check_block("held");
    handshake();

    // 6: reset mid-message discards the partial block
    for (int i = 0; i < 5; i++)
      send(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0, 4'd0);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_lane0", blk_data[63:0], 64'h0);
    check_eq("midrst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(64'h61, 1'b1, 4'd1);
    clear_exp();
    exp_l[0]  = 64'h0661;
    exp_l[16] = 64'h8000_0000_0000_0000;
    check_eq("a_valid", 64'(blk_valid), 64'd1);
    check_eq("a_last", 64'(blk_last), 64'd1);
    check_block("a");
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
